// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised rx, oversampled on b_tick, LSB-first,
// registered rx_done / frame_err strobes.
//
// state   | meaning
// IDLE    | line idle, watching rx_s for a falling edge every clk
// START   | counting to mid start bit to reject glitches
// DATA    | sampling data bits at mid bit, LSB first
// STOP    | sampling stop bit at mid bit; deliver byte or flag frame error
// WAIT_HI | bad stop seen; wait for line to return high (break guard)
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 done_n, err_n;
  logic                 rx_meta, rx_s;
  logic [DATA_BITS:0]   shift_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign shift_ext = {rx_s, shift};

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    data_n  = rx_data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        // edge detect runs every clk; a coincident b_tick is deliberately not counted
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (b_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (b_tick) begin
          if (tick_cnt == TICK_END) begin
            tick_n  = '0;
            shift_n = shift_ext[DATA_BITS:1];
            if (bit_cnt == BIT_LAST) state_n = STOP;
            else bit_n = bit_cnt + BW'(1);
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (b_tick) begin
          if (tick_cnt == TICK_END) begin
            tick_n = '0;
            if (rx_s) begin
              data_n  = shift;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = WAIT_HI;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      WAIT_HI: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      rx_data   <= data_n;
      rx_done   <= done_n;
      frame_err <= err_n;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised frame-level bench for uart_rx: frames are bit-banged on rx and the
// expected delivered bytes / frame errors are tracked per frame.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = TICK_DIV * OS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: what the receiver should have produced so far
  int         exp_done = 0;
  int         exp_err = 0;
  logic [7:0] last_good = 8'h00;

  // monitor observations
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         hold_viol = 0;
  int         excl_viol = 0;
  logic [7:0] prev_data = 8'h00;
  logic       rst_d = 1'b1;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .b_tick    (b_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      b_tick = (c == TICK_DIV - 1);
      c = (c + 1) % TICK_DIV;
    end
  end

  always @(negedge clk) begin
    if (!reset && !rst_d) begin
      if (!rx_done && rx_data != prev_data) hold_viol++;
      if (rx_done && frame_err) excl_viol++;
    end
    if (!reset && rx_done) done_cnt++;
    if (!reset && frame_err) err_cnt++;
    prev_data = rx_data;
    rst_d = reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
    drive(stop, BIT_CLKS);
    if (stop) begin
      exp_done++;
      last_good = d;
    end else begin
      exp_err++;
    end
  endtask

  // checked at the end of the stop bit, before the line is driven further
  task automatic frame_check(input string tag, input logic stop);
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_err"}, err_cnt, exp_err);
    chk({tag, "_data"}, {24'h0, rx_data}, {24'h0, last_good});
    chk({tag, "_busy"}, {31'h0, rx_busy}, {31'h0, !stop});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, {24'h0, rx_data}, {24'h0, last_good});
    chk({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_err"}, err_cnt, exp_err);
  endtask

  initial begin
    logic [7:0] d;
    logic       good;
    int         gap;

    @(negedge clk);
    repeat (8) @(negedge clk);
    chk("rst_data", {24'h0, rx_data}, 32'h0);
    chk("rst_flags", {29'h0, rx_done, rx_busy, frame_err}, 32'h0);
    reset = 1'b0;
    drive(1'b1, BIT_CLKS);
    check_idle_outputs("post_rst");

    send_frame(8'h30, 1'b1);
    frame_check("f30", 1'b1);

    send_frame(8'h55, 1'b1);
    frame_check("f55", 1'b1);
    send_frame(8'hAA, 1'b1);
    frame_check("fAA", 1'b1);
    drive(1'b1, BIT_CLKS);

    // 4-tick low glitch: receiver must arm then fall back to IDLE silently
    drive(1'b0, 4 * TICK_DIV);
    drive(1'b1, 8);
    chk("glitch_armed", {31'h0, rx_busy}, 32'h1);
    drive(1'b1, 2 * BIT_CLKS);
    check_idle_outputs("glitch");

    send_frame(8'hFF, 1'b0);
    frame_check("brk", 1'b0);
    drive(1'b0, 3 * BIT_CLKS);
    chk("brk_hold_busy", {31'h0, rx_busy}, 32'h1);
    chk("brk_no_retrig", err_cnt, exp_err);
    drive(1'b1, 2 * BIT_CLKS);
    check_idle_outputs("brk_idle");
    send_frame(8'h41, 1'b1);
    frame_check("f41", 1'b1);
    drive(1'b1, BIT_CLKS);

    // reset during bit 4 of 0x3C
    d = 8'h3C;
    drive(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive(d[i], BIT_CLKS);
    drive(d[4], BIT_CLKS / 2);
    chk("mid_busy", {31'h0, rx_busy}, 32'h1);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_data", {24'h0, rx_data}, 32'h0);
    chk("mrst_flags", {29'h0, rx_done, rx_busy, frame_err}, 32'h0);
    last_good = 8'h00;
    reset = 1'b0;
    drive(1'b1, 2 * BIT_CLKS);
    check_idle_outputs("mrst_idle");
    send_frame(8'h7E, 1'b1);
    frame_check("f7E", 1'b1);

    for (int n = 0; n < 40; n++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(d, good);
      frame_check("rnd", good);
      if (good) begin
        gap = $urandom_range(0, 2 * BIT_CLKS);
        if (gap > 0) drive(1'b1, gap);
      end else begin
        gap = $urandom_range(0, BIT_CLKS);
        if (gap > 0) drive(1'b0, gap);
        drive(1'b1, $urandom_range(8, 2 * BIT_CLKS));
      end
    end
    drive(1'b1, BIT_CLKS);
    check_idle_outputs("final");

    chk("data_hold", hold_viol, 0);
    chk("pulse_excl", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
